muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set operand and result width; legal values are even and at least 8.
REQ-002 Parameter TAG_W, default 5, SHALL set the width of the destination-register tag carried with each operation.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be an asynchronous, active-high reset.
REQ-005 in_valid  input  1  SHALL mark that an operation request is presented.
REQ-006 in_ready  output  1  SHALL mark that the unit accepts a request this cycle.
REQ-007 funct3  input  3  SHALL select the operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-008 op_a, op_b  input  WIDTH  SHALL carry rs1 and rs2 operand values.
REQ-009 tag_in  input  TAG_W  SHALL carry the destination tag; tag_out  output  TAG_W  SHALL return it unchanged.
REQ-010 out_valid  output  1  SHALL mark that result and tag_out are valid.
REQ-011 out_ready  input  1  SHALL mark that the consumer takes the result this cycle.
REQ-012 result  output  WIDTH  SHALL carry the operation result.
REQ-013 illegal  output  1  SHALL flag, alongside out_valid, an operation not supported by this build.

Function
REQ-014 The FSM SHALL have states IDLE, CALC and DONE; in_ready SHALL equal (state==IDLE); out_valid SHALL equal (state==DONE).
REQ-015 An edge with in_valid and in_ready high SHALL latch funct3, the operands and tag_in, then move to CALC; from then on, input changes SHALL be ignored until the next acceptance.
REQ-016 CALC SHALL run exactly WIDTH radix-2 iterations on a down-counter, shift-add for multiply and restoring shift-subtract for divide, then move to DONE; out_valid SHALL rise WIDTH cycles after the accepting edge.
REQ-017 Multiplies SHALL form the 2*WIDTH-bit product with operand signedness per RV32M; MUL SHALL return the low half; MULH, MULHSU and MULHU SHALL return the high half.
REQ-018 Signed divide SHALL operate on magnitudes; the quotient SHALL be negated when the operand signs differ, and the remainder SHALL take the dividend's sign; quotients truncate toward zero.
REQ-019 Divide by zero SHALL skip CALC and reach DONE one cycle after acceptance; the quotient SHALL be all-ones and the remainder SHALL be op_a.
REQ-020 Signed overflow, DIV or REM with op_a = most-negative and op_b = -1, SHALL reach DONE one cycle after acceptance, with quotient = op_a and remainder = 0.
REQ-021 In DONE, result, tag_out and illegal SHALL hold stable while out_ready is low; an edge with out_ready high SHALL return the FSM to IDLE; a new request SHALL NOT be accepted in that same cycle.
REQ-022 All arithmetic SHALL wrap modulo 2^WIDTH, except that the multiply accumulator is 2*WIDTH bits wide.

Reset
REQ-023 Asserting rst SHALL immediately force state IDLE and zero the counter, result, tag_out and illegal; out_valid SHALL read 0 and in_ready 1.
REQ-024 rst asserted mid-CALC or mid-DONE SHALL abandon the operation with no result delivered; the first acceptance after release SHALL behave per REQ-015.

Configuration
REQ-025 With macro MULDIV_DIV_EN defined, all eight operations SHALL be supported.
REQ-026 Without MULDIV_DIV_EN, no divide datapath SHALL be built; funct3 100-111 SHALL reach DONE one cycle after acceptance with result 0 and illegal = 1.

Structure
REQ-027 Package muldiv_pkg SHALL hold the funct3 operation codes, the FSM state type and the divide-by-zero and overflow result rules.
REQ-028 The per-iteration add/subtract-and-shift datapath SHALL be sub-module muldiv_step; muldiv_unit SHALL hold the FSM, counter, sign fix-up and handshake.

Verification
REQ-029 WIDTH=32, MUL, op_a=7, op_b=0xFFFFFFFD -> result 0xFFFFFFEB, out_valid 32 cycles after acceptance.
REQ-030 MULH, op_a=op_b=0x80000000 -> 0x40000000; MULHU, op_a=op_b=0xFFFFFFFF -> 0xFFFFFFFE.
REQ-031 DIV, op_a=0xFFFFFFF9 (-7), op_b=2 -> 0xFFFFFFFD; REM with the same operands -> 0xFFFFFFFF.
REQ-032 DIVU, op_a=0x1234, op_b=0 -> 0xFFFFFFFF; REMU with the same operands -> 0x1234; DIV, op_a=0x80000000, op_b=0xFFFFFFFF -> 0x80000000; each one cycle after acceptance.
REQ-033 out_ready held low for 5 cycles in DONE -> result, tag_out and out_valid stable, in_ready 0; then out_ready high -> IDLE next cycle.
REQ-034 rst pulsed 10 cycles into CALC -> out_valid never rises for that operation; the next request completes correctly with its own tag. Without MULDIV_DIV_EN, DIV -> illegal 1, result 0.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation codes,
// FSM states and the rules for divide results that bypass the iteration loop.
package muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // Width-independent description of a bypass result
  typedef enum logic [1:0] {
    SPC_ZERO     = 2'b00,
    SPC_ONES     = 2'b01,
    SPC_DIVIDEND = 2'b10
  } spc_sel_t;

  // Divide by zero: quotient all-ones, remainder is the dividend
  function automatic spc_sel_t div_zero_rule(input logic is_rem);
    if (is_rem) begin
      return SPC_DIVIDEND;
    end else begin
      return SPC_ONES;
    end
  endfunction

  // Signed overflow (most-negative / -1): quotient is the dividend, remainder 0
  function automatic spc_sel_t div_ovf_rule(input logic is_rem);
    if (is_rem) begin
      return SPC_ZERO;
    end else begin
      return SPC_DIVIDEND;
    end
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract for
// divide (divide path only with MULDIV_DIV_EN defined).
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
`ifdef MULDIV_DIV_EN
  input  logic             is_div,
`endif
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] hi_next,
  output logic [WIDTH-1:0] lo_next
);

  logic [WIDTH:0]   sum_s;
  logic [WIDTH-1:0] mul_hi_s;
  logic [WIDTH-1:0] mul_lo_s;
`ifdef MULDIV_DIV_EN
  logic [WIDTH:0]   rem_sh_s;
  logic [WIDTH:0]   diff_s;
`endif

  // Next accumulator {hi, lo} for the selected operation
  always_comb begin
    sum_s = {1'b0, hi} + {1'b0, operand};
    if (lo[0]) begin
      {mul_hi_s, mul_lo_s} = {sum_s, lo[WIDTH-1:1]};
    end else begin
      {mul_hi_s, mul_lo_s} = {1'b0, hi, lo[WIDTH-1:1]};
    end
`ifdef MULDIV_DIV_EN
    // hi stays below the divisor, so the shifted remainder fits WIDTH+1 bits
    rem_sh_s = {hi, lo[WIDTH-1]};
    diff_s   = rem_sh_s - {1'b0, operand};
    if (is_div) begin
      if (!diff_s[WIDTH]) begin
        hi_next = diff_s[WIDTH-1:0];
        lo_next = {lo[WIDTH-2:0], 1'b1};
      end else begin
        hi_next = rem_sh_s[WIDTH-1:0];
        lo_next = {lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_next = mul_hi_s;
      lo_next = mul_lo_s;
    end
`else
    hi_next = mul_hi_s;
    lo_next = mul_lo_s;
`endif
  end

endmodule

// File: rtl/muldiv_unit.sv
// RV32M-style iterative multiply/divide unit with valid/ready handshakes.
// Divide/remainder support is built only when MULDIV_DIV_EN is defined.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [TAG_W-1:0] tag_in,
  output logic [TAG_W-1:0] tag_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             illegal
);

  localparam int               CNT_W     = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] WIDTH_CNT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] ONE_CNT   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ONE_W     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_2W  = {{(2*WIDTH-1){1'b0}}, 1'b1};

  state_t             state_r, state_s;
  logic [CNT_W-1:0]   count_r;
  logic [2:0]         op_r;
  logic [TAG_W-1:0]   tag_r;
  logic [WIDTH-1:0]   hi_r, lo_r, mcand_r, result_r;
  logic               neg_r, special_r, ill_pend_r, illegal_r;
  logic               a_neg_s, b_neg_s, special_s, ill_s;
  logic [WIDTH-1:0]   a_mag_s, b_mag_s, special_val_s, hi_n_s, lo_n_s, final_s;
  logic [2*WIDTH-1:0] prod_s, prod_fix_s;
  spc_sel_t           sel_s;
`ifdef MULDIV_DIV_EN
  logic               rem_neg_r, div0_s, ovf_s;
  logic [WIDTH-1:0]   quot_s, rem_s;
`endif

  assign in_ready  = (state_r == ST_IDLE);
  assign out_valid = (state_r == ST_DONE);
  assign result    = result_r;
  assign tag_out   = tag_r;
  assign illegal   = illegal_r;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
`ifdef MULDIV_DIV_EN
    .is_div  (op_r[2]),
`endif
    .hi      (hi_r),
    .lo      (lo_r),
    .operand (mcand_r),
    .hi_next (hi_n_s),
    .lo_next (lo_n_s)
  );

  // Operand magnitudes and bypass classification of the presented request
  always_comb begin
    a_neg_s = op_a[WIDTH-1] & ((funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                               (funct3 == F3_DIV)  || (funct3 == F3_REM));
    b_neg_s = op_b[WIDTH-1] & ((funct3 == F3_MULH) || (funct3 == F3_DIV) ||
                               (funct3 == F3_REM));
    a_mag_s = a_neg_s ? (~op_a + ONE_W) : op_a;
    b_mag_s = b_neg_s ? (~op_b + ONE_W) : op_b;
    sel_s   = SPC_ZERO;
`ifdef MULDIV_DIV_EN
    div0_s    = funct3[2] && (op_b == {WIDTH{1'b0}});
    ovf_s     = funct3[2] && !funct3[0] && (op_a == {1'b1, {(WIDTH-1){1'b0}}}) &&
                (op_b == {WIDTH{1'b1}});
    special_s = div0_s || ovf_s;
    ill_s     = 1'b0;
    if (div0_s) begin
      sel_s = div_zero_rule(funct3[1]);
    end else if (ovf_s) begin
      sel_s = div_ovf_rule(funct3[1]);
    end else begin
      sel_s = SPC_ZERO;
    end
`else
    special_s = funct3[2];
    ill_s     = funct3[2];
`endif
    case (sel_s)
      SPC_ONES:     special_val_s = {WIDTH{1'b1}};
      SPC_DIVIDEND: special_val_s = op_a;
      SPC_ZERO:     special_val_s = {WIDTH{1'b0}};
      default:      special_val_s = {WIDTH{1'b0}};
    endcase
  end

  // Sign fix-up and half selection of the last iteration's accumulator
  always_comb begin
    prod_s     = {hi_n_s, lo_n_s};
    prod_fix_s = neg_r ? (~prod_s + ONE_2W) : prod_s;
    if (op_r == F3_MUL) begin
      final_s = prod_fix_s[WIDTH-1:0];
    end else begin
      final_s = prod_fix_s[2*WIDTH-1:WIDTH];
    end
`ifdef MULDIV_DIV_EN
    quot_s = neg_r ? (~lo_n_s + ONE_W) : lo_n_s;
    rem_s  = rem_neg_r ? (~hi_n_s + ONE_W) : hi_n_s;
    if (op_r[2]) begin
      final_s = op_r[1] ? rem_s : quot_s;
    end else begin
      final_s = final_s;
    end
`endif
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next state
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: state_s = in_valid ? ST_CALC : ST_IDLE;
      ST_CALC: state_s = (count_r == ONE_CNT) ? ST_DONE : ST_CALC;
      ST_DONE: state_s = out_ready ? ST_IDLE : ST_DONE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Request capture, iteration and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r    <= {CNT_W{1'b0}};
      op_r       <= 3'b000;
      tag_r      <= {TAG_W{1'b0}};
      hi_r       <= {WIDTH{1'b0}};
      lo_r       <= {WIDTH{1'b0}};
      mcand_r    <= {WIDTH{1'b0}};
      result_r   <= {WIDTH{1'b0}};
      neg_r      <= 1'b0;
      special_r  <= 1'b0;
      ill_pend_r <= 1'b0;
      illegal_r  <= 1'b0;
`ifdef MULDIV_DIV_EN
      rem_neg_r  <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            op_r       <= funct3;
            tag_r      <= tag_in;
            neg_r      <= a_neg_s ^ b_neg_s;
            special_r  <= special_s;
            ill_pend_r <= ill_s;
`ifdef MULDIV_DIV_EN
            rem_neg_r  <= a_neg_s;
`endif
            // Bypass results park in hi_r for one CALC cycle so every
            // latency is counted from the accepting edge the same way
            if (special_s) begin
              hi_r    <= special_val_s;
              lo_r    <= {WIDTH{1'b0}};
              mcand_r <= {WIDTH{1'b0}};
              count_r <= ONE_CNT;
            end else if (funct3[2]) begin
              hi_r    <= {WIDTH{1'b0}};
              lo_r    <= a_mag_s;
              mcand_r <= b_mag_s;
              count_r <= WIDTH_CNT;
            end else begin
              hi_r    <= {WIDTH{1'b0}};
              lo_r    <= b_mag_s;
              mcand_r <= a_mag_s;
              count_r <= WIDTH_CNT;
            end
          end
        end
        ST_CALC: begin
          hi_r    <= hi_n_s;
          lo_r    <= lo_n_s;
          count_r <= count_r - ONE_CNT;
          if (count_r == ONE_CNT) begin
            result_r  <= special_r ? hi_r : final_s;
            illegal_r <= ill_pend_r;
          end
        end
        ST_DONE: begin
          count_r <= count_r;
        end
        default: begin
          count_r <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (WIDTH=32): directed RV32M cases plus
// randomized operations against a 64-bit arithmetic reference model.
module tb_muldiv_unit;

  localparam int W  = 32;
  localparam int TW = 5;

  logic          clk, rst, in_valid, in_ready, out_valid, out_ready, illegal;
  logic [2:0]    funct3;
  logic [W-1:0]  op_a, op_b, result;
  logic [TW-1:0] tag_in, tag_out;

  int n_checks = 0;
  int n_pass   = 0;

  muldiv_unit #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .funct3(funct3), .op_a(op_a), .op_b(op_b), .tag_in(tag_in),
    .tag_out(tag_out), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  // Reference: RV32M semantics computed with 64-bit integer arithmetic
  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, ubs;
    longint unsigned ua, ub;
    logic [63:0]     t;
    sa = $signed(a); sb = $signed(b);
    ua = {32'h0, a}; ub = {32'h0, b}; ubs = {32'h0, b};
    if (f[2] && !DIV_EN) return 32'h0;
    case (f)
      3'd0: begin t = ua * ub;  return t[31:0];  end
      3'd1: begin t = sa * sb;  return t[63:32]; end
      3'd2: begin t = sa * ubs; return t[63:32]; end
      3'd3: begin t = ua * ub;  return t[63:32]; end
      3'd4: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        t = sa / sb; return t[31:0];
      end
      3'd5: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        t = ua / ub; return t[31:0];
      end
      3'd6: begin
        if (b == 32'h0) return a;
        t = sa % sb; return t[31:0];
      end
      default: begin
        if (b == 32'h0) return a;
        t = ua % ub; return t[31:0];
      end
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (!f[2]) return 32;
    if (!DIV_EN || b == 32'h0) return 1;
    if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 32;
  endfunction

  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tg, input int hold);
    logic [31:0] er;
    logic        ei;
    int          k;
    er = ref_result(f, a, b);
    ei = f[2] && !DIV_EN;
    @(negedge clk);
    funct3 = f; op_a = a; op_b = b; tag_in = tg; in_valid = 1'b1; out_ready = 1'b0;
    check_val("in_ready_idle", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    // Inputs after acceptance must be ignored
    in_valid = 1'b0; funct3 = 3'($urandom); op_a = $urandom; op_b = $urandom; tag_in = 5'($urandom);
    k = 0;
    while (out_valid !== 1'b1 && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    check_val($sformatf("latency f%0d", f), 64'(k), 64'(ref_latency(f, a, b)));
    check_val($sformatf("result f%0d a=%h b=%h", f, a, b), 64'(result), 64'(er));
    check_val("tag_out", 64'(tag_out), 64'(tg));
    check_val("illegal", 64'(illegal), 64'(ei));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check_val("done_hold", {27'h0, out_valid, in_ready, illegal, tag_out, result},
                {27'h0, 1'b1, 1'b0, ei, tg, er});
    end
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    check_val("release_no_accept", {62'h0, out_valid, in_ready}, 64'd1);
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  logic [2:0]  d_f[8] = '{3'd0, 3'd1, 3'd3, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4};
  logic [31:0] d_a[8] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
                          32'hFFFF_FFF9, 32'h1234, 32'h1234, 32'h8000_0000};
  logic [31:0] d_b[8] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd2,
                          32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF};

  initial begin
    bit seen;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; funct3 = 3'd0;
    op_a = 32'h0; op_b = 32'h0; tag_in = 5'd0;
    #1;
    check_val("reset_state", {25'h0, in_ready, out_valid, illegal, tag_out, result},
              {25'h0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0});
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_op(d_f[i], d_a[i], d_b[i], 5'(i + 1), 1);
    run_op(3'd0, 32'd123, 32'd456, 5'd17, 5);

    // Reset abandons an operation 10 cycles into CALC
    @(negedge clk);
    funct3 = 3'd0; op_a = 32'd9; op_b = 32'd9; tag_in = 5'd21; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1 check_val("async_reset", {25'h0, in_ready, out_valid, illegal, tag_out, result},
                 {25'h0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0});
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check_val("no_result_after_rst", 64'(seen), 64'd0);
    run_op(3'd1, 32'hFFFF_FFFE, 32'd3, 5'd30, 0);

    for (int i = 0; i < 150; i++) begin
      run_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand(),
             5'($urandom), $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
